// File: rtl/uart_tx_framer.sv
//-----------------------------------------------------------------------------
// uart_tx_framer
//
// UART transmit framer. A byte offered on a single-cycle Data_Valid strobe
// while the framer is idle is latched and sent as: one start bit (0), data
// bits LSB first, an optional parity bit and one stop bit (1). Every bit is
// held for Prescale clock cycles, which matches the oversampling ratio used
// by the receive path.
//
// Ports
//   CLK         in   1           system clock, rising edge
//   RST         in   1           synchronous reset, active low
//   P_DATA      in   DATA_WIDTH  parallel data, sampled on acceptance
//   Data_Valid  in   1           request strobe, accepted when Busy is low
//   PAR_EN      in   1           1 = insert parity bit (sampled on acceptance)
//   PAR_TYP     in   1           0 = even, 1 = odd (sampled on acceptance)
//   Prescale    in   6           clock cycles per bit, 0 is treated as 1
//   TX_OUT      out  1           serial line, registered, idles high
//   Busy        out  1           registered, high for the whole frame
//
// Configuration
//   UART_TX_PARITY_EN  defined   : PARITY state and parity generation exist.
//                      undefined : PAR_EN / PAR_TYP are ignored, frames never
//                                  carry a parity bit.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Parity over the latched data word: even = XOR, odd = XNOR.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    calc_parity = odd ? ~(^data) : (^data);
  endfunction
`endif

  state_t                  state_r;
  state_t                  state_s;
  logic [5:0]              edge_cnt_r;
  logic [5:0]              edge_cnt_s;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [BIT_W-1:0]        bit_cnt_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [5:0]              prescale_r;
  logic                    tx_out_r;
  logic                    tx_out_s;
  logic                    busy_r;
  logic                    busy_s;
  logic                    accept_s;
  logic                    bit_end_s;
  logic                    last_bit_s;
`ifdef UART_TX_PARITY_EN
  logic                    par_en_r;
  logic                    par_typ_r;
`else
  // Parity controls have no function in this build.
  logic                    unused_par_s;
  assign unused_par_s = PAR_EN ^ PAR_TYP;
`endif

  assign accept_s   = (state_r == ST_IDLE) && Data_Valid;
  // prescale_r is never 0, so P-1 cannot underflow.
  assign bit_end_s  = (edge_cnt_r == (prescale_r - 6'd1));
  assign last_bit_s = (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));

  // Frame parameter capture on acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_r     <= '0;
      prescale_r <= 6'd1;
`ifdef UART_TX_PARITY_EN
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
`endif
    end else if (accept_s) begin
      data_r     <= P_DATA;
      prescale_r <= (Prescale == 6'd0) ? 6'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
      par_en_r   <= PAR_EN;
      par_typ_r  <= PAR_TYP;
`endif
    end else begin
      data_r     <= data_r;
      prescale_r <= prescale_r;
`ifdef UART_TX_PARITY_EN
      par_en_r   <= par_en_r;
      par_typ_r  <= par_typ_r;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic: every non-idle state lasts exactly one bit time.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Data_Valid) state_s = ST_START;
        else            state_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_s = ST_DATA;
        else           state_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && last_bit_s) begin
`ifdef UART_TX_PARITY_EN
          state_s = par_en_r ? ST_PARITY : ST_STOP;
`else
          state_s = ST_STOP;
`endif
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) state_s = ST_STOP;
        else           state_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (bit_end_s) state_s = ST_IDLE;
        else           state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Edge and bit counter next values.
  always_comb begin
    edge_cnt_s = edge_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    if (state_r == ST_IDLE) begin
      edge_cnt_s = 6'd0;
    end else if (bit_end_s) begin
      edge_cnt_s = 6'd0;
    end else begin
      edge_cnt_s = edge_cnt_r + 6'd1;
    end
    if (state_r != ST_DATA) begin
      bit_cnt_s = '0;
    end else if (bit_end_s) begin
      bit_cnt_s = last_bit_s ? '0 : (bit_cnt_r + BIT_W'(1));
    end else begin
      bit_cnt_s = bit_cnt_r;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt_r <= 6'd0;
      bit_cnt_r  <= '0;
    end else begin
      edge_cnt_r <= edge_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
    end
  end

  // FSM output logic, decoded from the next state so the registered line
  // shows the start bit in the same cycle Busy rises.
  always_comb begin
    tx_out_s = 1'b1;
    busy_s   = 1'b0;
    case (state_s)
      ST_IDLE: begin
        tx_out_s = 1'b1;
        busy_s   = 1'b0;
      end
      ST_START: begin
        tx_out_s = 1'b0;
        busy_s   = 1'b1;
      end
      ST_DATA: begin
        tx_out_s = data_r[bit_cnt_s];
        busy_s   = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_out_s = calc_parity(data_r, par_typ_r);
        busy_s   = 1'b1;
      end
`endif
      ST_STOP: begin
        tx_out_s = 1'b1;
        busy_s   = 1'b1;
      end
      default: begin
        tx_out_s = 1'b1;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Output flops keep the serial line glitch-free.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_out_r <= tx_out_s;
      busy_r   <= busy_s;
    end
  end

  assign TX_OUT = tx_out_r;
  assign Busy   = busy_r;

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

UART transmit framer: accepts a parallel byte on a single-cycle valid strobe and serialises it as start bit, data bits LSB first, optional parity bit and one stop bit. Each bit is held for `Prescale` clock cycles, so bit timing uses the same oversampling ratio as the receive side. It sits between the system-side TX data source and the serial line, and is the transmit counterpart of the UART receive path.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `P_DATA`  in  DATA_WIDTH  parallel data; sampled only on acceptance.
- `Data_Valid`  in  1  request strobe; accepted when high and `Busy` low.
- `PAR_EN`  in  1  parity bit inserted when 1; sampled on acceptance.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on acceptance.
- `Prescale`  in  6  clock cycles per bit; sampled on acceptance.
- `TX_OUT`  out  1  serial line, registered, idle high.
- `Busy`  out  1  registered, high for the whole frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `Busy`=0. If `Data_Valid`=1, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`, then go to START.
- Latched `Prescale`=0 is treated as 1. Input changes after acceptance have no effect on the current frame.
- Edge counter: 6-bit, counts 0..P-1, where P is the latched prescale. A bit ends in the cycle where the counter equals P-1. The counter then wraps to 0 and the FSM advances.
- Bit counter: 0..DATA_WIDTH-1 during DATA. DATA exits after bit DATA_WIDTH-1 ends.
- START drives 0. DATA drives `data[bit_cnt]`, LSB first. PARITY drives the parity bit. STOP drives 1.
- DATA goes to PARITY if latched `PAR_EN`=1, otherwise to STOP.
- STOP goes to IDLE when its last cycle ends.
- Parity is computed over the latched data:
  - even: `^data`
  - odd: `~^data`
- `Data_Valid` while `Busy`=1 is ignored and the request is not queued.
- There is at least one IDLE cycle between frames.
- Reset (`RST`=0 at a rising edge) overrides everything. On the next edge: state IDLE, counters 0, `TX_OUT`=1, `Busy`=0. A frame in progress is aborted with no partial stop bit.

## Timing
- Reset values: `TX_OUT`=1, `Busy`=0, edge_cnt=0, bit_cnt=0, state IDLE.
- Acceptance at edge k means that after edge k, `Busy`=1 and `TX_OUT`=0 (start bit). Latency from the accepting edge to the line is 0 cycles.
- Each bit occupies exactly P cycles.
- Frame length is N = P*(DATA_WIDTH+2+parity) cycles. `Busy` is high for exactly N cycles, then falls together with the return to IDLE.
- Earliest next acceptance is the edge after `Busy` falls, so the back-to-back period is N+1 cycles.
- `TX_OUT` and `Busy` are driven from flops only, so the line is glitch-free.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state and parity logic are present, and `PAR_EN`/`PAR_TYP` behave as described above.
- Undefined: PARITY state and parity logic are removed. `PAR_EN` and `PAR_TYP` are ignored and DATA always goes to STOP. Frame length is P*(DATA_WIDTH+2).

## Test plan
- Reset, then 0xA5, P=8, `PAR_EN`=0 → `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. `Busy` high 80 cycles.
- 0xA5, P=4, even parity → parity bit 0, frame 11 bits. `Busy` high 44 cycles.
- 0x01, P=4, odd parity → parity bit 0. 0x03 with odd parity → parity bit 1.
- Pulse `Data_Valid` with 0xFF mid-frame of 0x00 → only 0x00 is transmitted, and `TX_OUT` returns high after the stop bit with no second frame.
- P=0 and P=1 → 1 cycle per bit, 10-cycle frame. `Data_Valid` held high → next start bit begins 11 cycles after the first.
- `RST` low during DATA bit 3 → after the next edge, `TX_OUT`=1 and `Busy`=0. A new request afterwards produces a clean full frame.
